// File: rtl/udp_chk_pkg.sv
// Shared types and default constants for the UDP receive-data checker.
package udp_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR_WAIT,
        HDR_CHK,
        STREAM
    } state_t;

    typedef enum logic [1:0] {
        SEQ,
        PAY_FIRST,
        PAY
    } tag_t;

    localparam logic [31:0] MAGIC_DEF    = 32'h3a87c5d6;
    localparam logic [31:0] PAT_SEED_DEF = 32'h00010203;
    localparam logic [31:0] PAT_INC_DEF  = 32'h04040404;

endpackage

// File: rtl/udp_chk_sat_cnt.sv
// Saturating event counter with synchronous clear taking priority.
module udp_chk_sat_cnt #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/udp_datain_check_p.sv
// Link-integrity monitor: reads each completed ping-pong bank and checks
// header magic, frame sequence continuity and the incrementing payload.
module udp_datain_check_p
    import udp_chk_pkg::*;
#(
    parameter int             DW        = 32,
    parameter int             AW        = 9,
    parameter int             CW        = 16,
    parameter int             MAGIC_IDX = 11,
    parameter logic [DW-1:0]  MAGIC     = DW'(MAGIC_DEF),
    parameter int             SEQ_IDX   = 13,
    parameter int             PAY_START = 16,
    parameter int             PAY_END   = 250,
    parameter logic [DW-1:0]  PAT_SEED  = DW'(PAT_SEED_DEF),
    parameter logic [DW-1:0]  PAT_INC   = DW'(PAT_INC_DEF)
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          clr,
    input  logic          pingpong,
    input  logic [DW-1:0] ram_rdata,
    output logic [AW:0]   ram_addr,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_err,
    output logic          err_sticky,
    output logic [CW-1:0] err_magic_cnt,
    output logic [CW-1:0] err_seq_cnt,
    output logic [CW-1:0] err_pat_cnt,
    output logic [CW-1:0] frame_ok_cnt,
    output logic [CW-1:0] frame_miss_cnt
);

    logic          r_pp_s1, r_pp_s2;
    state_t        r_state, w_next;
    logic          r_bank, w_bank_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic          r_pv, w_pv_nxt;
    tag_t          r_ptag, w_ptag_nxt;
    logic          r_plast, w_plast_nxt;
    logic          r_iss_end, w_iss_nxt;
    logic [DW-1:0] r_prev, r_last_seq;
    logic          r_seq_valid, r_ferr;
    logic          r_done, r_err, r_sticky;

    logic          w_toggle, w_magic_ok, w_hdr_bad;
    logic          w_seq_chk, w_seq_bad, w_pay_chk, w_pat_bad;
    logic          w_last, w_frame_bad, w_ok_inc, w_miss;
    logic [DW-1:0] w_pay_exp;

    assign w_toggle    = r_pp_s1 ^ r_pp_s2;
    assign w_magic_ok  = (ram_rdata == MAGIC);
    assign w_hdr_bad   = (r_state == HDR_CHK) && !w_magic_ok;
    assign w_seq_chk   = (r_state == STREAM) && r_pv && (r_ptag == SEQ);
    assign w_seq_bad   = w_seq_chk && r_seq_valid &&
                         (ram_rdata != r_last_seq + DW'(1));
    assign w_pay_chk   = (r_state == STREAM) && r_pv && (r_ptag != SEQ);
    // Chained off the received word so one bad word costs two counts.
    assign w_pay_exp   = (r_ptag == PAY_FIRST) ? PAT_SEED : r_prev + PAT_INC;
    assign w_pat_bad   = w_pay_chk && (ram_rdata != w_pay_exp);
    assign w_last      = (r_state == STREAM) && r_pv && r_plast;
    assign w_frame_bad = r_ferr | w_pat_bad | w_seq_bad;
    assign w_ok_inc    = w_last && !w_frame_bad;
    assign w_miss      = w_toggle && (r_state != IDLE);

    assign ram_addr   = {r_bank, r_idx};
    assign busy       = (r_state != IDLE);
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign err_sticky = r_sticky;

    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (w_toggle) w_next = HDR_WAIT;
            HDR_WAIT: w_next = HDR_CHK;
            HDR_CHK:  w_next = w_magic_ok ? STREAM : IDLE;
            STREAM:   if (w_last) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_bank_nxt  = r_bank;
        w_idx_nxt   = r_idx;
        w_pv_nxt    = 1'b0;
        w_ptag_nxt  = r_ptag;
        w_plast_nxt = 1'b0;
        w_iss_nxt   = r_iss_end;
        unique case (r_state)
            IDLE: begin
                if (w_toggle) begin
                    w_bank_nxt = r_pp_s2;
                    w_idx_nxt  = AW'(MAGIC_IDX);
                end
            end
            HDR_WAIT: w_idx_nxt = AW'(SEQ_IDX);
            HDR_CHK: begin
                if (w_magic_ok) begin
                    w_idx_nxt  = AW'(PAY_START);
                    w_pv_nxt   = 1'b1;
                    w_ptag_nxt = SEQ;
                    w_iss_nxt  = 1'b0;
                end
            end
            STREAM: begin
                if (!r_iss_end) begin
                    w_pv_nxt    = 1'b1;
                    w_ptag_nxt  = (r_idx == AW'(PAY_START)) ? PAY_FIRST : PAY;
                    w_plast_nxt = (r_idx == AW'(PAY_END));
                    if (r_idx == AW'(PAY_END))
                        w_iss_nxt = 1'b1;
                    else
                        w_idx_nxt = r_idx + AW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_pp_s1     <= 1'b0;
            r_pp_s2     <= 1'b0;
            r_bank      <= 1'b0;
            r_idx       <= '0;
            r_pv        <= 1'b0;
            r_ptag      <= SEQ;
            r_plast     <= 1'b0;
            r_iss_end   <= 1'b0;
            r_prev      <= '0;
            r_last_seq  <= '0;
            r_seq_valid <= 1'b0;
            r_ferr      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            r_pp_s1   <= pingpong;
            r_pp_s2   <= r_pp_s1;
            r_bank    <= w_bank_nxt;
            r_idx     <= w_idx_nxt;
            r_pv      <= w_pv_nxt;
            r_ptag    <= w_ptag_nxt;
            r_plast   <= w_plast_nxt;
            r_iss_end <= w_iss_nxt;
            if (w_pay_chk)
                r_prev <= ram_rdata;
            if (w_seq_chk)
                r_last_seq <= ram_rdata;
            if (clr)
                r_seq_valid <= 1'b0;
            else if (w_seq_chk)
                r_seq_valid <= 1'b1;
            if (r_state == HDR_CHK)
                r_ferr <= 1'b0;
            else if (w_seq_bad || w_pat_bad)
                r_ferr <= 1'b1;
            r_done <= w_hdr_bad | w_last;
            r_err  <= w_hdr_bad | (w_last & w_frame_bad);
            if (clr)
                r_sticky <= 1'b0;
            else if (w_hdr_bad || w_seq_bad || w_pat_bad || w_miss)
                r_sticky <= 1'b1;
        end
    end

    udp_chk_sat_cnt #(.CW(CW)) u_magic (
        .clk(clk), .rst(RST), .clr(clr), .inc(w_hdr_bad), .cnt(err_magic_cnt)
    );
    udp_chk_sat_cnt #(.CW(CW)) u_seq (
        .clk(clk), .rst(RST), .clr(clr), .inc(w_seq_bad), .cnt(err_seq_cnt)
    );
    udp_chk_sat_cnt #(.CW(CW)) u_pat (
        .clk(clk), .rst(RST), .clr(clr), .inc(w_pat_bad), .cnt(err_pat_cnt)
    );
    udp_chk_sat_cnt #(.CW(CW)) u_ok (
        .clk(clk), .rst(RST), .clr(clr), .inc(w_ok_inc), .cnt(frame_ok_cnt)
    );
    udp_chk_sat_cnt #(.CW(CW)) u_miss (
        .clk(clk), .rst(RST), .clr(clr), .inc(w_miss), .cnt(frame_miss_cnt)
    );

endmodule

// File: tb/tb_udp_datain_check_p.sv
// Directed + randomized bench for udp_datain_check_p against a frame-level model.
module tb_udp_datain_check_p;

    localparam logic [31:0] MAGIC = 32'h3a87c5d6;
    localparam logic [31:0] SEED  = 32'h00010203;
    localparam logic [31:0] INC   = 32'h04040404;
    localparam int          LAT   = 240;
    localparam int          SATV  = 15;

    logic        clk = 1'b0;
    logic        RST, clr, pingpong;
    logic [31:0] ram_rdata;
    logic [9:0]  ram_addr;
    logic        busy, frame_done, frame_err, err_sticky;
    logic [3:0]  c_magic, c_seq, c_pat, c_ok, c_miss;

    logic [31:0] mem [0:1023];
    int          pay_cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;

    int          m_magic, m_seqc, m_pat, m_ok, m_miss;
    bit          m_sticky, m_sv;
    logic [31:0] m_last;

    udp_datain_check_p #(.CW(4)) dut (
        .clk(clk), .RST(RST), .clr(clr), .pingpong(pingpong),
        .ram_rdata(ram_rdata), .ram_addr(ram_addr), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err),
        .err_sticky(err_sticky), .err_magic_cnt(c_magic),
        .err_seq_cnt(c_seq), .err_pat_cnt(c_pat),
        .frame_ok_cnt(c_ok), .frame_miss_cnt(c_miss)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= mem[ram_addr];

    always @(negedge clk)
        if (busy && ram_addr[8:0] >= 9'd16) pay_cyc <= pay_cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > SATV) ? SATV : x;
    endfunction

    task automatic fill(input bit b, input logic [31:0] seq,
                        input logic [31:0] magic);
        for (int i = 0; i < 512; i++) mem[{b, 9'(i)}] = $urandom;
        mem[{b, 9'd11}] = magic;
        mem[{b, 9'd13}] = seq;
        for (int i = 16; i <= 250; i++)
            mem[{b, 9'(i)}] = SEED + INC * 32'(i - 16);
    endtask

    task automatic model(input bit b, output bit e, output int lat);
        logic [31:0] s, prev, exp;
        e = 1'b0;
        lat = LAT;
        if (mem[{b, 9'd11}] != MAGIC) begin
            m_magic++; m_sticky = 1'b1; e = 1'b1; lat = 4;
            return;
        end
        s = mem[{b, 9'd13}];
        if (m_sv && s != m_last + 32'd1) begin
            m_seqc++; m_sticky = 1'b1; e = 1'b1;
        end
        m_last = s;
        m_sv = 1'b1;
        prev = '0;
        for (int i = 16; i <= 250; i++) begin
            exp = (i == 16) ? SEED : prev + INC;
            if (mem[{b, 9'(i)}] != exp) begin
                m_pat++; m_sticky = 1'b1; e = 1'b1;
            end
            prev = mem[{b, 9'(i)}];
        end
        if (!e) m_ok++;
    endtask

    task automatic model_clear();
        m_magic = 0; m_seqc = 0; m_pat = 0; m_ok = 0; m_miss = 0;
        m_sticky = 1'b0; m_sv = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, ":magic"}, 32'(c_magic), 32'(sat(m_magic)));
        chk({tag, ":seq"}, 32'(c_seq), 32'(sat(m_seqc)));
        chk({tag, ":pat"}, 32'(c_pat), 32'(sat(m_pat)));
        chk({tag, ":ok"}, 32'(c_ok), 32'(sat(m_ok)));
        chk({tag, ":miss"}, 32'(c_miss), 32'(sat(m_miss)));
        chk({tag, ":sticky"}, 32'(err_sticky), 32'(m_sticky));
    endtask

    task automatic wait_done(input string tag, input int exp_n,
                             input int tog_at, input bit exp_err);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (n < 600) begin
            @(negedge clk);
            n++;
            if (frame_done) begin
                got = 1'b1;
                break;
            end
            if (n == tog_at) pingpong = ~pingpong;
        end
        chk({tag, ":done_seen"}, 32'(got), 32'd1);
        chk({tag, ":latency"}, 32'(n), 32'(exp_n));
        chk({tag, ":frame_err"}, 32'(frame_err), 32'(exp_err));
    endtask

    task automatic go(input string tag, input int tog_at);
        bit e;
        int lat;
        model(pingpong, e, lat);
        @(negedge clk);
        pingpong = ~pingpong;
        wait_done(tag, lat, tog_at, e);
        check_counts(tag);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    initial begin
        bit          b0, e;
        int          lat, p0, k;
        logic [31:0] s;

        RST = 1'b1; clr = 1'b0; pingpong = 1'b0;
        model_clear();
        m_last = '0;
        fill(1'b0, 32'd0, MAGIC);
        fill(1'b1, 32'd0, MAGIC);
        repeat (3) @(negedge clk);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:addr", 32'(ram_addr), 32'd0);
        chk("rst:done", 32'(frame_done), 32'd0);
        chk("rst:err", 32'(frame_err), 32'd0);
        check_counts("rst");
        RST = 1'b0;
        repeat (3) @(negedge clk);

        fill(pingpong, 32'd5, MAGIC); go("good5", 0);
        fill(pingpong, 32'd6, MAGIC); go("good6", 0);
        fill(pingpong, 32'd7, MAGIC); go("good7", 0);

        fill(pingpong, 32'd100, 32'hdeadbeef);
        p0 = pay_cyc;
        go("badmagic", 0);
        chk("badmagic:pay_addr", 32'(pay_cyc - p0), 32'd0);
        fill(pingpong, 32'd8, MAGIC); go("seed_kept", 0);

        fill(pingpong, 32'd10, MAGIC); go("seqgap", 0);
        fill(pingpong, 32'hffffffff, MAGIC); go("seq_ff", 0);
        fill(pingpong, 32'd0, MAGIC); go("seq_wrap", 0);

        pulse_clr();
        check_counts("clr1");
        fill(pingpong, 32'd9, MAGIC); go("after_clr", 0);

        fill(pingpong, 32'd10, MAGIC);
        mem[{pingpong, 9'd100}] ^= 32'd1;
        go("corrupt100", 0);
        fill(pingpong, 32'd11, MAGIC);
        mem[{pingpong, 9'd16}] = 32'd0;
        go("word16_zero", 0);

        for (int r = 0; r < 4; r++) begin
            s = ($urandom_range(0, 1) == 1) ? m_last + 32'd1 : $urandom;
            fill(pingpong, s, MAGIC);
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++)
                mem[{pingpong, 9'($urandom_range(16, 250))}] ^= ($urandom | 32'd1);
            go("random", 0);
        end

        pulse_clr();
        fill(pingpong, 32'd20, MAGIC);
        m_miss++;
        m_sticky = 1'b1;
        go("miss", 50);

        b0 = pingpong;
        fill(b0, 32'd21, MAGIC);
        fill(~b0, 32'd22, MAGIC);
        model(b0, e, lat);
        @(negedge clk);
        pingpong = ~pingpong;
        wait_done("b2b_a", lat, lat - 1, e);
        check_counts("b2b_a");
        model(~b0, e, lat);
        wait_done("b2b_b", lat - 1, 0, e);
        check_counts("b2b_b");

        pulse_clr();
        fill(pingpong, 32'd30, MAGIC);
        for (int j = 0; j < 10; j++)
            mem[{pingpong, 9'(20 + 10 * j)}] ^= 32'h00000100;
        go("saturate", 0);
        pulse_clr();
        check_counts("clr2");

        fill(pingpong, 32'd40, MAGIC); go("pre_rst", 0);
        fill(pingpong, 32'd41, MAGIC);
        @(negedge clk);
        pingpong = ~pingpong;
        repeat (100) @(negedge clk);
        RST = 1'b1;
        pingpong = 1'b0;
        #1;
        chk("midrst:busy", 32'(busy), 32'd0);
        chk("midrst:addr", 32'(ram_addr), 32'd0);
        chk("midrst:done", 32'(frame_done), 32'd0);
        model_clear();
        check_counts("midrst");
        @(negedge clk);
        RST = 1'b0;
        repeat (5) @(negedge clk);
        chk("postrst:busy", 32'(busy), 32'd0);
        fill(pingpong, 32'd42, MAGIC); go("recover", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
